hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 30 +++
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline hazard signals between the datapath and hazard_ctrl
interface hazard_ctrl_if;
  logic       id_valid;
  logic       id_src1_used;
  logic       id_src2_used;
  logic [2:0] id_src1;
  logic [2:0] id_src2;
  logic       PR2_MEM_read;
  logic       PR2_RF_write_en;
  logic [2:0] PR2_dest;
  logic       branch_taken;
  logic       mem_busy;
  logic       pc_write_en;
  logic       PR1_write_en;
  logic       PR2_write_en;
  logic       PR1_flush;
  logic       PR2_flush;

  modport master (
    output id_valid, id_src1_used, id_src2_used, id_src1, id_src2,
    output PR2_MEM_read, PR2_RF_write_en, PR2_dest, branch_taken, mem_busy,
    input  pc_write_en, PR1_write_en, PR2_write_en, PR1_flush, PR2_flush
  );

  modport slave (
    input  id_valid, id_src1_used, id_src2_used, id_src1, id_src2,
    input  PR2_MEM_read, PR2_RF_write_en, PR2_dest, branch_taken, mem_busy,
    output pc_write_en, PR1_write_en, PR2_write_en, PR1_flush, PR2_flush
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, memory wait and branch flush control
// with stall/flush performance counters.
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_if.slave     hif,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  localparam logic [2:0] BCNT_INIT = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic load_use;
  logic pc_en, pr1_en, pr2_en, pr1_fl, pr2_fl, branch_flush;

  always_comb begin
    load_use = hif.PR2_MEM_read & hif.PR2_RF_write_en & (hif.PR2_dest != 3'd0) &
               hif.id_valid &
               ((hif.id_src1_used & (hif.id_src1 == hif.PR2_dest)) |
                (hif.id_src2_used & (hif.id_src2 == hif.PR2_dest)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      bcnt_q  <= 3'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // MEM_WAIT with memory ready is evaluated exactly like RUN.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      LU_STALL: begin
        if (hif.branch_taken) begin
          state_d = RUN;
          bcnt_d  = 3'd0;
        end else if (hif.mem_busy) begin
          state_d = LU_STALL;
        end else if (bcnt_q <= 3'd1) begin
          state_d = RUN;
          bcnt_d  = 3'd0;
        end else begin
          bcnt_d = bcnt_q - 3'd1;
        end
      end
      default: begin
        if (state_q == MEM_WAIT && hif.mem_busy) begin
          state_d = MEM_WAIT;
        end else if (hif.branch_taken) begin
          state_d = RUN;
        end else if (hif.mem_busy) begin
          state_d = MEM_WAIT;
        end else if (load_use && LOAD_STALL_CYCLES > 1) begin
          state_d = LU_STALL;
          bcnt_d  = BCNT_INIT;
        end else begin
          state_d = RUN;
        end
      end
    endcase
  end

  always_comb begin
    pc_en        = 1'b1;
    pr1_en       = 1'b1;
    pr2_en       = 1'b1;
    pr1_fl       = 1'b0;
    pr2_fl       = 1'b0;
    branch_flush = 1'b0;
    if (rst) begin
      pc_en  = 1'b0;
      pr1_en = 1'b0;
      pr2_en = 1'b0;
      pr1_fl = 1'b1;
      pr2_fl = 1'b1;
    end else if (state_q == MEM_WAIT && hif.mem_busy) begin
      pc_en  = 1'b0;
      pr1_en = 1'b0;
      pr2_en = 1'b0;
    end else if (hif.branch_taken) begin
      pr1_fl       = 1'b1;
      pr2_fl       = 1'b1;
      branch_flush = 1'b1;
    end else if (hif.mem_busy) begin
      pc_en  = 1'b0;
      pr1_en = 1'b0;
      pr2_en = 1'b0;
    end else if (state_q == LU_STALL || load_use) begin
      pc_en  = 1'b0;
      pr1_en = 1'b0;
      pr2_fl = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_en && stall_q != CNT_MAX) stall_d = stall_q + CNT_W'(1);
    if (branch_flush && flush_q != CNT_MAX) flush_d = flush_q + CNT_W'(1);
  end

  always_comb begin
    hif.pc_write_en  = pc_en;
    hif.PR1_write_en = pr1_en;
    hif.PR2_write_en = pr2_en;
    hif.PR1_flush    = pr1_fl;
    hif.PR2_flush    = pr2_fl;
    stall_cycles     = stall_q;
    flush_count      = flush_q;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed checks of hazard_ctrl with 1, 3 and 5 stall cycles
module tb_hazard_ctrl;

  // {pc_write_en, PR1_write_en, PR2_write_en, PR1_flush, PR2_flush}
  localparam logic [4:0] NORMAL = 5'b11100;
  localparam logic [4:0] BUBBLE = 5'b00101;
  localparam logic [4:0] FREEZE = 5'b00000;
  localparam logic [4:0] FLUSH  = 5'b11111;
  localparam logic [4:0] RESET  = 5'b00011;

  logic       clk;
  logic       rst;
  logic       id_valid, id_src1_used, id_src2_used;
  logic [2:0] id_src1, id_src2, pr2_dest;
  logic       pr2_mem_read, pr2_rf_we, branch_taken, mem_busy;

  int total = 0;
  int bad   = 0;

  wire [4:0]  ctl       [3];
  wire [15:0] stall_cnt [3];
  wire [15:0] flush_cnt [3];

  hazard_ctrl_if u_if[3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign u_if[g].id_valid        = id_valid;
    assign u_if[g].id_src1_used    = id_src1_used;
    assign u_if[g].id_src2_used    = id_src2_used;
    assign u_if[g].id_src1         = id_src1;
    assign u_if[g].id_src2         = id_src2;
    assign u_if[g].PR2_MEM_read    = pr2_mem_read;
    assign u_if[g].PR2_RF_write_en = pr2_rf_we;
    assign u_if[g].PR2_dest        = pr2_dest;
    assign u_if[g].branch_taken    = branch_taken;
    assign u_if[g].mem_busy        = mem_busy;
    assign ctl[g] = {u_if[g].pc_write_en, u_if[g].PR1_write_en, u_if[g].PR2_write_en,
                     u_if[g].PR1_flush, u_if[g].PR2_flush};

    hazard_ctrl #(
      .LOAD_STALL_CYCLES((g == 0) ? 1 : ((g == 1) ? 3 : 5)),
      .CNT_W            (16)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .hif         (u_if[g]),
      .stall_cycles(stall_cnt[g]),
      .flush_count (flush_cnt[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid     = 1'b0;
    id_src1_used = 1'b0;
    id_src2_used = 1'b0;
    id_src1      = 3'd0;
    id_src2      = 3'd0;
    pr2_mem_read = 1'b0;
    pr2_rf_we    = 1'b0;
    pr2_dest     = 3'd0;
    branch_taken = 1'b0;
    mem_busy     = 1'b0;
  endtask

  task automatic load_in_ex(input logic u1, input logic [2:0] s1,
                            input logic u2, input logic [2:0] s2, input logic [2:0] dest);
    id_valid     = 1'b1;
    id_src1_used = u1;
    id_src1      = s1;
    id_src2_used = u2;
    id_src2      = s2;
    pr2_mem_read = 1'b1;
    pr2_rf_we    = 1'b1;
    pr2_dest     = dest;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    chk("rst_ctl", 32'(ctl[0]), 32'(RESET));
    chk("rst_stall", 32'(stall_cnt[0]), 32'd0);
    chk("rst_flush", 32'(flush_cnt[0]), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ctl", 32'(ctl[0]), 32'(NORMAL));

    // load-use on src2, one and three bubbles
    load_in_ex(1'b0, 3'd0, 1'b1, 3'd3, 3'd3);
    #1;
    chk("lu1_entry", 32'(ctl[0]), 32'(BUBBLE));
    chk("lu3_entry", 32'(ctl[1]), 32'(BUBBLE));
    tick();
    idle();
    #1;
    chk("lu1_done", 32'(ctl[0]), 32'(NORMAL));
    chk("lu1_stall", 32'(stall_cnt[0]), 32'd1);
    chk("lu3_b2", 32'(ctl[1]), 32'(BUBBLE));
    tick();
    chk("lu3_b3", 32'(ctl[1]), 32'(BUBBLE));
    tick();
    chk("lu3_done", 32'(ctl[1]), 32'(NORMAL));
    chk("lu3_stall", 32'(stall_cnt[1]), 32'd3);

    // no-hazard patterns
    do_reset();
    load_in_ex(1'b1, 3'd0, 1'b0, 3'd0, 3'd0);
    #1;
    chk("r0_dest", 32'(ctl[0]), 32'(NORMAL));
    load_in_ex(1'b1, 3'd2, 1'b0, 3'd3, 3'd3);
    #1;
    chk("unused_src", 32'(ctl[0]), 32'(NORMAL));
    load_in_ex(1'b1, 3'd3, 1'b0, 3'd0, 3'd3);
    id_valid = 1'b0;
    #1;
    chk("id_invalid", 32'(ctl[0]), 32'(NORMAL));
    load_in_ex(1'b1, 3'd3, 1'b0, 3'd0, 3'd3);
    pr2_mem_read = 1'b0;
    #1;
    chk("not_load", 32'(ctl[0]), 32'(NORMAL));
    tick();
    chk("nohaz_stall", 32'(stall_cnt[0]), 32'd0);

    // branch flush, and branch beats load-use
    do_reset();
    branch_taken = 1'b1;
    #1;
    chk("br_ctl", 32'(ctl[0]), 32'(FLUSH));
    tick();
    idle();
    #1;
    chk("br_after", 32'(ctl[0]), 32'(NORMAL));
    chk("br_flush_cnt", 32'(flush_cnt[0]), 32'd1);
    chk("br_stall_cnt", 32'(stall_cnt[0]), 32'd0);
    load_in_ex(1'b1, 3'd5, 1'b0, 3'd0, 3'd5);
    branch_taken = 1'b1;
    #1;
    chk("br_over_lu", 32'(ctl[0]), 32'(FLUSH));

    // memory wait with branch pending
    do_reset();
    mem_busy = 1'b1;
    #1;
    chk("mw_c1", 32'(ctl[0]), 32'(FREEZE));
    tick();
    branch_taken = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      #1;
      chk($sformatf("mw_c%0d", i), 32'(ctl[0]), 32'(FREEZE));
      tick();
    end
    mem_busy = 1'b0;
    #1;
    chk("mw_release", 32'(ctl[0]), 32'(FLUSH));
    tick();
    idle();
    #1;
    chk("mw_after", 32'(ctl[0]), 32'(NORMAL));
    chk("mw_stall", 32'(stall_cnt[0]), 32'd4);
    chk("mw_flush", 32'(flush_cnt[0]), 32'd1);

    // mem_busy freezes the bubble count, branch aborts the stall
    do_reset();
    load_in_ex(1'b1, 3'd4, 1'b0, 3'd0, 3'd4);
    tick();
    idle();
    mem_busy = 1'b1;
    #1;
    chk("lus_freeze", 32'(ctl[1]), 32'(FREEZE));
    tick();
    mem_busy = 1'b0;
    #1;
    chk("lus_b2", 32'(ctl[1]), 32'(BUBBLE));
    tick();
    chk("lus_b3", 32'(ctl[1]), 32'(BUBBLE));
    tick();
    chk("lus_done", 32'(ctl[1]), 32'(NORMAL));
    chk("lus_stall", 32'(stall_cnt[1]), 32'd4);
    do_reset();
    load_in_ex(1'b1, 3'd4, 1'b0, 3'd0, 3'd4);
    tick();
    idle();
    branch_taken = 1'b1;
    #1;
    chk("lus_br", 32'(ctl[1]), 32'(FLUSH));
    tick();
    idle();
    #1;
    chk("lus_br_after", 32'(ctl[1]), 32'(NORMAL));

    // reset in the middle of a five-bubble stall
    do_reset();
    load_in_ex(1'b0, 3'd0, 1'b1, 3'd6, 3'd6);
    tick();
    idle();
    tick();
    tick();
    chk("l5_mid", 32'(ctl[2]), 32'(BUBBLE));
    chk("l5_mid_stall", 32'(stall_cnt[2]), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("l5_rst_ctl", 32'(ctl[2]), 32'(RESET));
    chk("l5_rst_stall", 32'(stall_cnt[2]), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("l5_after_rst", 32'(ctl[2]), 32'(NORMAL));
    tick();
    chk("l5_run", 32'(ctl[2]), 32'(NORMAL));
    chk("l5_run_stall", 32'(stall_cnt[2]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
